// File: rtl/ysyx_22040750_mdu_ctrl_if.sv
// Handshake bundle between the ID/EX stage and the multicycle mul/div controller.
// master drives requests and consumes controller strobes; slave is the controller.
interface ysyx_22040750_mdu_ctrl_if;
    logic       I_start;
    logic [3:0] I_op_sel;
    logic       I_word_op;
    logic       I_divisor_zero;
    logic       I_allowout;
    logic       I_flush;
    logic       O_load;
    logic       O_step;
    logic [6:0] O_step_cnt;
    logic       O_sel_div;
    logic       O_div_zero_bypass;
    logic       O_busy;
    logic       O_alu_output_valid;
    logic       O_err;

    modport master (
        output I_start, I_op_sel, I_word_op, I_divisor_zero, I_allowout, I_flush,
        input  O_load, O_step, O_step_cnt, O_sel_div, O_div_zero_bypass,
        input  O_busy, O_alu_output_valid, O_err
    );

    modport slave (
        input  I_start, I_op_sel, I_word_op, I_divisor_zero, I_allowout, I_flush,
        output O_load, O_step, O_step_cnt, O_sel_div, O_div_zero_bypass,
        output O_busy, O_alu_output_valid, O_err
    );
endinterface

// File: rtl/ysyx_22040750_mdu_ctrl.sv
// Iterative mul/div sequencer: result valid N+2 cycles after start (2 on divide-by-zero).
// Result is held in DONE until I_allowout; I_flush aborts from any state.
module ysyx_22040750_mdu_ctrl #(
    parameter int XLEN = 64
) (
    input  logic                       I_sys_clk,
    input  logic                       I_rst_n,
    ysyx_22040750_mdu_ctrl_if.slave    mdu
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

    state_e     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic       word_q, sel_div_q, dz_q;
    logic       accept;
    logic       err;
    logic       op_legal;
    logic [6:0] last_cnt;

    assign op_legal = (mdu.I_op_sel != 4'd0) &&
                      ((mdu.I_op_sel & (mdu.I_op_sel - 4'd1)) == 4'd0);
    assign last_cnt = word_q ? 7'd31 : 7'(XLEN - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        err     = 1'b0;
        if (mdu.I_flush) begin
            state_d = IDLE;
            cnt_d   = 7'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mdu.I_start) begin
                        if (op_legal) begin
                            accept  = 1'b1;
                            state_d = LOAD;
                        end else begin
                            err = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    cnt_d   = 7'd0;
                    state_d = (sel_div_q && dz_q) ? DONE : RUN;
                end
                RUN: begin
                    if (cnt_q == last_cnt) begin
                        cnt_d   = 7'd0;
                        state_d = DONE;
                    end else begin
                        cnt_d = 7'(cnt_q + 7'd1);
                    end
                end
                DONE: begin
                    // Back-to-back issue: a new start in the release cycle skips IDLE.
                    if (mdu.I_allowout) begin
                        if (mdu.I_start && op_legal) begin
                            accept  = 1'b1;
                            state_d = LOAD;
                        end else begin
                            err     = mdu.I_start;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        mdu.O_load             = (state_q == LOAD);
        mdu.O_step             = (state_q == RUN);
        mdu.O_step_cnt         = cnt_q;
        mdu.O_sel_div          = sel_div_q && (state_q != IDLE);
        mdu.O_div_zero_bypass  = (state_q == DONE) && sel_div_q && dz_q;
        mdu.O_busy             = (state_q == LOAD) || (state_q == RUN);
        mdu.O_alu_output_valid = ((state_q == IDLE) && !mdu.I_start) || (state_q == DONE);
        mdu.O_err              = err;
    end

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 7'd0;
            word_q    <= 1'b0;
            sel_div_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (mdu.I_flush) begin
                dz_q <= 1'b0;
            end else if (accept) begin
                word_q    <= mdu.I_word_op;
                sel_div_q <= mdu.I_op_sel[2] | mdu.I_op_sel[3];
                dz_q      <= mdu.I_divisor_zero;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040750_mdu_ctrl.sv
// Directed plus randomized checks of the mul/div sequencer against a cycle-offset timing model.
module tb_ysyx_22040750_mdu_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    ysyx_22040750_mdu_ctrl_if mif();

    ysyx_22040750_mdu_ctrl #(.XLEN(64)) dut (
        .I_sys_clk (clk),
        .I_rst_n   (rst_n),
        .mdu       (mif)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] ev(input bit load, input bit step, input int cnt,
                                       input bit sel, input bit byp, input bit busy,
                                       input bit valid, input bit err);
        logic [6:0] c;
        c = 7'(cnt);
        return {load, step, c, sel, byp, busy, valid, err};
    endfunction

    localparam logic [13:0] IDLE_V = 14'b00_0000000_0001_0;

    // Expected outputs k cycles after the start edge, from the latency rules alone.
    function automatic logic [13:0] exp_at(input logic [3:0] op, input bit word,
                                           input bit dz, input int k);
        bit is_div;
        bit byp;
        int n;
        int total;
        is_div = op[2] | op[3];
        byp    = is_div & dz;
        n      = word ? 32 : 64;
        total  = byp ? 2 : n + 2;
        if (k == 1)          return ev(1, 0, 0, is_div, 0, 1, 0, 0);
        else if (k < total)  return ev(0, 1, k - 2, is_div, 0, 1, 0, 0);
        else                 return ev(0, 0, 0, is_div, byp, 0, 1, 0);
    endfunction

    function automatic int total_of(input logic [3:0] op, input bit word, input bit dz);
        return ((op[2] | op[3]) & dz) ? 2 : (word ? 34 : 66);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [13:0] exp);
        logic [13:0] obs;
        #1;
        obs = {mif.O_load, mif.O_step, mif.O_step_cnt, mif.O_sel_div, mif.O_div_zero_bypass,
               mif.O_busy, mif.O_alu_output_valid, mif.O_err};
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [3:0] op, input bit word, input bit dz);
        mif.I_start        = 1'b1;
        mif.I_op_sel       = op;
        mif.I_word_op      = word;
        mif.I_divisor_zero = dz;
        mif.I_allowout     = 1'b1;
        check("start_cycle", ev(0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        mif.I_start = 1'b0;
    endtask

    task automatic walk(input logic [3:0] op, input bit word, input bit dz, input int upto);
        for (int k = 1; k < upto; k++) begin
            check($sformatf("op%b_w%0d_k%0d", op, word, k), exp_at(op, word, dz, k));
            tick();
        end
    endtask

    task automatic run_body(input logic [3:0] op, input bit word, input bit dz, input int stall,
                            input bit chain, input logic [3:0] nop, input bit nword, input bit ndz);
        int total;
        total = total_of(op, word, dz);
        walk(op, word, dz, total);
        for (int s = 0; s < stall; s++) begin
            mif.I_allowout = 1'b0;
            check($sformatf("done_stall%0d", s), exp_at(op, word, dz, total));
            tick();
        end
        mif.I_allowout = 1'b1;
        if (chain) begin
            mif.I_start        = 1'b1;
            mif.I_op_sel       = nop;
            mif.I_word_op      = nword;
            mif.I_divisor_zero = ndz;
        end
        check("done_release", exp_at(op, word, dz, total));
        tick();
        mif.I_start = 1'b0;
    endtask

    logic [3:0] cop, nop;
    bit         cword, cdz, nword, ndz, ch;

    initial begin
        mif.I_start        = 1'b0;
        mif.I_op_sel       = 4'b0001;
        mif.I_word_op      = 1'b0;
        mif.I_divisor_zero = 1'b0;
        mif.I_allowout     = 1'b1;
        mif.I_flush        = 1'b0;
        check("reset_state", IDLE_V);
        tick();
        rst_n = 1'b1;
        check("idle_after_reset", IDLE_V);

        // 64-bit mul, then divw, then rem by zero
        start_op(4'b0001, 1'b0, 1'b0);
        run_body(4'b0001, 1'b0, 1'b0, 0, 1'b0, 4'b0001, 1'b0, 1'b0);
        check("idle_after_mul", IDLE_V);
        start_op(4'b0100, 1'b1, 1'b0);
        run_body(4'b0100, 1'b1, 1'b0, 0, 1'b0, 4'b0001, 1'b0, 1'b0);
        start_op(4'b1000, 1'b0, 1'b1);
        run_body(4'b1000, 1'b0, 1'b1, 0, 1'b0, 4'b0001, 1'b0, 1'b0);

        // Stall 5 cycles, then chain a new start in the release cycle
        start_op(4'b0010, 1'b1, 1'b0);
        run_body(4'b0010, 1'b1, 1'b0, 5, 1'b1, 4'b0001, 1'b1, 1'b0);
        run_body(4'b0001, 1'b1, 1'b0, 0, 1'b0, 4'b0001, 1'b0, 1'b0);

        // Illegal selects
        mif.I_start  = 1'b1;
        mif.I_op_sel = 4'b0101;
        check("illegal_0101", ev(0, 0, 0, 0, 0, 0, 0, 1));
        tick();
        mif.I_start = 1'b0;
        check("after_illegal", IDLE_V);
        mif.I_start  = 1'b1;
        mif.I_op_sel = 4'b0000;
        check("illegal_0000", ev(0, 0, 0, 0, 0, 0, 0, 1));
        tick();
        mif.I_start = 1'b0;
        check("after_illegal0", IDLE_V);

        // Flush beats start in IDLE, suppresses err
        mif.I_start  = 1'b1;
        mif.I_flush  = 1'b1;
        mif.I_op_sel = 4'b0001;
        check("flush_start", ev(0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        mif.I_op_sel = 4'b0011;
        check("flush_illegal", ev(0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        mif.I_start = 1'b0;
        mif.I_flush = 1'b0;
        check("idle_after_flush_start", IDLE_V);

        // Flush at cnt=10
        start_op(4'b0001, 1'b0, 1'b0);
        walk(4'b0001, 1'b0, 1'b0, 12);
        mif.I_flush = 1'b1;
        check("flush_cnt10", exp_at(4'b0001, 1'b0, 1'b0, 12));
        tick();
        mif.I_flush = 1'b0;
        check("after_flush_run", IDLE_V);

        // Flush in DONE overrides start+allowout
        start_op(4'b0100, 1'b0, 1'b1);
        walk(4'b0100, 1'b0, 1'b1, 2);
        mif.I_flush    = 1'b1;
        mif.I_start    = 1'b1;
        mif.I_allowout = 1'b1;
        check("flush_done", exp_at(4'b0100, 1'b0, 1'b1, 2));
        tick();
        mif.I_flush = 1'b0;
        mif.I_start = 1'b0;
        check("after_flush_done", IDLE_V);

        // Asynchronous reset at cnt=20
        start_op(4'b0001, 1'b0, 1'b0);
        walk(4'b0001, 1'b0, 1'b0, 22);
        rst_n = 1'b0;
        check("async_reset", IDLE_V);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("post_reset%0d", i), IDLE_V);
            tick();
        end

        // Randomized ops with random stalls and chaining
        cop   = 4'b0001 << $urandom_range(0, 3);
        cword = 1'($urandom_range(0, 1));
        cdz   = ($urandom_range(0, 2) == 0);
        start_op(cop, cword, cdz);
        for (int i = 0; i < 24; i++) begin
            nop   = 4'b0001 << $urandom_range(0, 3);
            nword = 1'($urandom_range(0, 1));
            ndz   = ($urandom_range(0, 2) == 0);
            ch    = (i != 23) && ($urandom_range(0, 1) == 1);
            run_body(cop, cword, cdz, $urandom_range(0, 3), ch, nop, nword, ndz);
            if (!ch) begin
                check($sformatf("rand_idle%0d", i), IDLE_V);
                if (i != 23) start_op(nop, nword, ndz);
            end
            cop   = nop;
            cword = nword;
            cdz   = ndz;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22040750_mdu_ctrl.md
YSYX_22040750_MDU_CTRL -- requirements
Module: ysyx_22040750_mdu_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, the full-width operand width, which sets the iteration count.
REQ-002 SHALL have port I_sys_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port I_rst_n, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port I_start, input, 1, the multicycle-op request pulse from the ID/EX stage register.
REQ-005 SHALL have port I_op_sel, input, 4, a one-hot op select: [0] mul, [1] mulh, [2] div, [3] rem.
REQ-006 SHALL have port I_word_op, input, 1, requesting a 32-bit (W) operation.
REQ-007 SHALL have port I_divisor_zero, input, 1, which is high when the divisor operand is 0; sampled with I_start.
REQ-008 SHALL have port I_allowout, input, 1, meaning the downstream stage accepts the result.
REQ-009 SHALL have port I_flush, input, 1, which aborts the current operation.
REQ-010 SHALL have port O_load, output, 1, a one-cycle datapath operand-load strobe.
REQ-011 SHALL have port O_step, output, 1, the datapath iteration enable.
REQ-012 SHALL have port O_step_cnt, output, 7, the current iteration index.
REQ-013 SHALL have port O_sel_div, output, 1, which is 1 when the latched op is div or rem.
REQ-014 SHALL have port O_div_zero_bypass, output, 1, telling the datapath to drive the RISC-V divide-by-zero result.
REQ-015 SHALL have port O_busy, output, 1, which is 1 in states LOAD and RUN.
REQ-016 SHALL have port O_alu_output_valid, output, 1, the result-valid signal to the ID/EX stage register.
REQ-017 SHALL have port O_err, output, 1, a one-cycle pulse on an illegal I_op_sel.

Function
REQ-018 SHALL implement the FSM states IDLE, LOAD, RUN and DONE.
REQ-019 SHALL, in IDLE, move to LOAD when I_start is high and I_op_sel is one-hot, latching op, word and divisor_zero.
REQ-020 SHALL, in IDLE, stay in IDLE when I_start is high and I_op_sel is zero or multi-hot, and pulse O_err for 1 cycle.
REQ-021 SHALL, in LOAD, assert O_load for exactly 1 cycle, then move to DONE with O_div_zero_bypass=1 if div/rem and divisor_zero, otherwise move to RUN with the counter cleared to 0.
REQ-022 SHALL, in RUN, hold O_step at 1 and increment O_step_cnt each cycle, moving to DONE after the step where O_step_cnt = N-1.
REQ-023 SHALL use N = XLEN (64) when word=0 and N = 32 when word=1.
REQ-024 SHALL make the latency from I_start to first O_alu_output_valid N+2 cycles, or 2 cycles on the divide-by-zero bypass.
REQ-025 SHALL drive O_alu_output_valid as (IDLE and not I_start) or DONE, with the I_start term combinational, so a single-cycle ALU op sees valid=1.
REQ-026 SHALL, in DONE, hold O_alu_output_valid and O_div_zero_bypass until I_allowout=1, then go to IDLE, or go directly to LOAD if I_start is high that same cycle.
REQ-027 SHALL ignore I_start while in LOAD or RUN.
REQ-028 SHALL, on I_flush=1 in any state, go to IDLE next cycle with the counter cleared, bypass cleared and no O_err; flush has priority over start and allowout.
REQ-029 SHALL keep O_sel_div stable from LOAD through DONE.
REQ-030 SHALL keep O_step_cnt at 0 outside RUN; it never wraps.

Reset
REQ-031 SHALL, while I_rst_n=0, immediately force state IDLE and drive O_load=0, O_step=0, O_step_cnt=0, O_sel_div=0, O_div_zero_bypass=0, O_busy=0, O_err=0 and O_alu_output_valid=1 (IDLE, I_start=0).
REQ-032 SHALL, when reset is asserted mid-RUN, abandon the operation and SHALL NOT produce any result-valid pulse after release.

Verification
REQ-033 SHALL pass this scenario: mul with word=0, I_allowout=1 -> O_load at cycle 1, O_step cycles 2-65 with cnt 0..63, valid at cycle 66, IDLE at cycle 67.
REQ-034 SHALL pass this scenario: divw with word=1 and divisor nonzero -> 32 steps, valid at cycle 34, O_sel_div=1 throughout.
REQ-035 SHALL pass this scenario: rem with I_divisor_zero=1 -> no O_step, valid with O_div_zero_bypass=1 at cycle 2.
REQ-036 SHALL pass this scenario: I_allowout held 0 for 5 cycles in DONE -> valid held for 5 cycles; then I_start with allowout in the same cycle -> next cycle LOAD.
REQ-037 SHALL pass this scenario: I_flush at cnt=10 -> IDLE next cycle and cnt=0; I_rst_n low at cnt=20 -> immediate IDLE with all outputs at reset values.
REQ-038 SHALL pass this scenario: I_start with I_op_sel=4'b0101 -> O_err pulses 1 cycle and the state stays IDLE.
